// File: rtl/robo_move_scheduler.sv
// Purpose: arbitrates manual/auto move commands and paces each move over v_sync frames.
// Latency: ack 1 cycle after request; done FRAMES_PER_MOVE ticks + 1 cycle after grant.
// Backpressure: requests are ignored outside IDLE; requesters hold req until ack. Option: ROBO_SCHED_FAIR_EN.
module robo_move_scheduler #(
  parameter int COLS            = 20,
  parameter int ROWS            = 15,
  parameter int FRAMES_PER_MOVE = 8,
  parameter int START_COL       = 0,
  parameter int START_ROW       = 0
) (
  input  logic       Clock50,
  input  logic       Reset,
  input  logic       v_sync,
  input  logic       man_req,
  input  logic [1:0] man_cmd,
  output logic       man_ack,
  input  logic       auto_req,
  input  logic [1:0] auto_cmd,
  output logic       auto_ack,
  input  logic       blocked,
  output logic [4:0] pos_col,
  output logic [3:0] pos_row,
  output logic [1:0] dir,
  output logic       busy,
  output logic [2:0] anim_frame,
  output logic [7:0] debris_cnt,
  output logic       done,
  output logic       bump
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_COMMIT} state_t;

  localparam logic [1:0] CMD_ADV  = 2'b00;
  localparam logic [1:0] CMD_TURN = 2'b01;
  localparam logic [1:0] CMD_REM  = 2'b10;
  localparam logic [1:0] CMD_NOP  = 2'b11;

  localparam logic [2:0] LAST_FRAME = 3'(FRAMES_PER_MOVE - 1);
  localparam logic [4:0] COL_MAX    = 5'(COLS - 1);
  localparam logic [3:0] ROW_MAX    = 4'(ROWS - 1);
  localparam logic [4:0] COL_INIT   = 5'(START_COL);
  localparam logic [3:0] ROW_INIT   = 4'(START_ROW);

  state_t     state, next_state;
  logic       vs_q;
  logic       tick;
  logic [1:0] cmd_q;
  logic       pick_man;
  logic       grant_any;
  logic [1:0] grant_cmd;
  logic       step_ok;

  logic       man_ack_d, auto_ack_d, busy_d, done_d, bump_d;
  logic [2:0] anim_frame_d;
  logic [4:0] pos_col_d;
  logic [3:0] pos_row_d;
  logic [1:0] dir_d;
  logic [7:0] debris_cnt_d;

  assign tick = vs_q & ~v_sync;

`ifdef ROBO_SCHED_FAIR_EN
  // last_grant: 1 = manual won last time, 0 = auto
  logic last_grant;
  assign pick_man = man_req & (~auto_req | ~last_grant);

  always_ff @(posedge Clock50) begin
    if (!Reset)         last_grant <= 1'b0;
    else if (grant_any) last_grant <= pick_man;
  end
`else
  assign pick_man = man_req;
`endif

  assign grant_any = (state == S_IDLE) & (man_req | auto_req);
  assign grant_cmd = pick_man ? man_cmd : auto_cmd;

  // A move may only step if not blocked and the target cell stays on the grid.
  always_comb begin
    step_ok = 1'b0;
    case (dir)
      2'b00:   step_ok = (pos_row != 4'd0);
      2'b01:   step_ok = (pos_col != COL_MAX);
      2'b10:   step_ok = (pos_row != ROW_MAX);
      default: step_ok = (pos_col != 5'd0);
    endcase
    step_ok = step_ok & ~blocked;
  end

  always_ff @(posedge Clock50) begin
    if (!Reset) begin
      state      <= S_IDLE;
      vs_q       <= 1'b1;
      cmd_q      <= CMD_NOP;
      man_ack    <= 1'b0;
      auto_ack   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bump       <= 1'b0;
      anim_frame <= 3'd0;
      pos_col    <= COL_INIT;
      pos_row    <= ROW_INIT;
      dir        <= 2'b01;
      debris_cnt <= 8'd0;
    end else begin
      state      <= next_state;
      vs_q       <= v_sync;
      if (grant_any) cmd_q <= grant_cmd;
      man_ack    <= man_ack_d;
      auto_ack   <= auto_ack_d;
      busy       <= busy_d;
      done       <= done_d;
      bump       <= bump_d;
      anim_frame <= anim_frame_d;
      pos_col    <= pos_col_d;
      pos_row    <= pos_row_d;
      dir        <= dir_d;
      debris_cnt <= debris_cnt_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (grant_any && grant_cmd != CMD_NOP) next_state = S_EXEC;
      S_EXEC:   if (tick && anim_frame == LAST_FRAME) next_state = S_COMMIT;
      S_COMMIT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    man_ack_d    = grant_any & pick_man;
    auto_ack_d   = grant_any & ~pick_man;
    busy_d       = (next_state == S_EXEC) || (next_state == S_COMMIT);
    done_d       = (state == S_COMMIT);
    bump_d       = 1'b0;
    anim_frame_d = anim_frame;
    pos_col_d    = pos_col;
    pos_row_d    = pos_row;
    dir_d        = dir;
    debris_cnt_d = debris_cnt;
    if (grant_any)
      anim_frame_d = 3'd0;
    else if (state == S_EXEC && tick)
      anim_frame_d = anim_frame + 3'd1;
    if (state == S_COMMIT) begin
      case (cmd_q)
        CMD_ADV: begin
          if (!step_ok) bump_d = 1'b1;
          else begin
            case (dir)
              2'b00:   pos_row_d = pos_row - 4'd1;
              2'b01:   pos_col_d = pos_col + 5'd1;
              2'b10:   pos_row_d = pos_row + 4'd1;
              default: pos_col_d = pos_col - 5'd1;
            endcase
          end
        end
        CMD_TURN: dir_d = dir + 2'd1;
        CMD_REM:  if (debris_cnt != 8'hFF) debris_cnt_d = debris_cnt + 8'd1;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_robo_move_scheduler.sv
// Directed bench for robo_move_scheduler: reset, moves, clamps, turns, debris, arbitration, nop, reset abort.
module tb_robo_move_scheduler;
  localparam int FPM = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v_sync = 1'b1;
  logic       man_req = 1'b0, auto_req = 1'b0, blocked = 1'b0;
  logic [1:0] man_cmd = 2'b11, auto_cmd = 2'b11;
  logic       man_ack, auto_ack, busy, done, bump;
  logic [4:0] pos_col;
  logic [3:0] pos_row;
  logic [1:0] dir;
  logic [2:0] anim_frame;
  logic [7:0] debris_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  robo_move_scheduler #(.COLS(20), .ROWS(15), .FRAMES_PER_MOVE(FPM), .START_COL(3), .START_ROW(2)) dut (
    .Clock50(clk), .Reset(rst_n), .v_sync(v_sync),
    .man_req(man_req), .man_cmd(man_cmd), .man_ack(man_ack),
    .auto_req(auto_req), .auto_cmd(auto_cmd), .auto_ack(auto_ack),
    .blocked(blocked), .pos_col(pos_col), .pos_row(pos_row), .dir(dir),
    .busy(busy), .anim_frame(anim_frame), .debris_cnt(debris_cnt),
    .done(done), .bump(bump)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_tick();
    v_sync = 1'b0;
    cyc(1);
    v_sync = 1'b1;
    cyc(1);
  endtask

  // Issue one command, drop the request after the ack, run FPM ticks, capture done/bump.
  task automatic run_move(input logic is_man, input logic [1:0] cmd, input logic blk,
                          output logic got_ack, output logic got_done, output logic got_bump);
    blocked = blk;
    if (is_man) begin man_req = 1'b1; man_cmd = cmd; end
    else begin auto_req = 1'b1; auto_cmd = cmd; end
    cyc(1);
    got_ack = is_man ? man_ack : auto_ack;
    man_req = 1'b0;
    auto_req = 1'b0;
    repeat (FPM) frame_tick();
    got_done = done;
    got_bump = bump;
    blocked = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    n_checks++;
    if ({pos_col, pos_row} !== {5'd3, 4'd2}) begin
      n_fail++; $display("FAIL reset_pos: got (%0d,%0d) expected (3,2)", pos_col, pos_row);
    end
    n_checks++;
    if (dir !== 2'b01 || debris_cnt !== 8'd0 || anim_frame !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: dir=%0d debris=%0d anim=%0d expected 1,0,0", dir, debris_cnt, anim_frame);
    end
    n_checks++;
    if ({busy, done, bump, man_ack, auto_ack} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 00000", {busy, done, bump, man_ack, auto_ack});
    end
  endtask

  task automatic test_advance();
    man_req = 1'b1; man_cmd = 2'b00;
    cyc(1);
    n_checks++;
    if ({man_ack, auto_ack, busy} !== 3'b101 || anim_frame !== 3'd0) begin
      n_fail++; $display("FAIL adv_grant: ack/aack/busy=%b anim=%0d expected 101,0", {man_ack, auto_ack, busy}, anim_frame);
    end
    man_req = 1'b0;
    cyc(1);
    n_checks++;
    if (man_ack !== 1'b0) begin
      n_fail++; $display("FAIL adv_ack_pulse: ack=%b expected 0", man_ack);
    end
    repeat (FPM - 1) frame_tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || anim_frame !== 3'd7) begin
      n_fail++; $display("FAIL adv_early: done=%b busy=%b anim=%0d expected 0,1,7", done, busy, anim_frame);
    end
    frame_tick();
    n_checks++;
    if (done !== 1'b1 || bump !== 1'b0 || {pos_col, pos_row} !== {5'd4, 4'd2}) begin
      n_fail++; $display("FAIL adv_commit: done=%b bump=%b pos=(%0d,%0d) expected 1,0,(4,2)", done, bump, pos_col, pos_row);
    end
    cyc(1);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL adv_after: done=%b busy=%b expected 0,0", done, busy);
    end
  endtask

  task automatic test_turn_wrap();
    logic a, d, b;
    logic [1:0] exp_dir [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
    for (int i = 0; i < 4; i++) begin
      run_move(1'b1, 2'b01, 1'b0, a, d, b);
      n_checks++;
      if (dir !== exp_dir[i] || d !== 1'b1) begin
        n_fail++; $display("FAIL turn_%0d: dir=%0d done=%b expected %0d,1", i, dir, d, exp_dir[i]);
      end
    end
  endtask

  task automatic test_edge_clamp();
    logic a, d, b;
    for (int i = 0; i < 15; i++) run_move(1'b0, 2'b00, 1'b0, a, d, b);
    n_checks++;
    if (pos_col !== 5'd19 || a !== 1'b1) begin
      n_fail++; $display("FAIL clamp_reach: col=%0d auto_ack=%b expected 19,1", pos_col, a);
    end
    run_move(1'b1, 2'b00, 1'b0, a, d, b);
    n_checks++;
    if ({d, b} !== 2'b11 || pos_col !== 5'd19 || pos_row !== 4'd2) begin
      n_fail++; $display("FAIL clamp_edge: done/bump=%b pos=(%0d,%0d) expected 11,(19,2)", {d, b}, pos_col, pos_row);
    end
  endtask

  task automatic test_blocked();
    logic a, d, b;
    run_move(1'b1, 2'b01, 1'b0, a, d, b);
    run_move(1'b1, 2'b00, 1'b1, a, d, b);
    n_checks++;
    if ({d, b} !== 2'b11 || pos_row !== 4'd2 || dir !== 2'b10) begin
      n_fail++; $display("FAIL blocked: done/bump=%b row=%0d dir=%0d expected 11,2,2", {d, b}, pos_row, dir);
    end
    run_move(1'b1, 2'b00, 1'b0, a, d, b);
    n_checks++;
    if ({d, b} !== 2'b10 || pos_row !== 4'd3) begin
      n_fail++; $display("FAIL south_step: done/bump=%b row=%0d expected 10,3", {d, b}, pos_row);
    end
  endtask

  task automatic test_debris();
    logic a, d, b;
    run_move(1'b1, 2'b10, 1'b0, a, d, b);
    n_checks++;
    if (debris_cnt !== 8'd1) begin
      n_fail++; $display("FAIL debris_first: got %0d expected 1", debris_cnt);
    end
    for (int i = 0; i < 254; i++) run_move(1'b1, 2'b10, 1'b0, a, d, b);
    n_checks++;
    if (debris_cnt !== 8'd255) begin
      n_fail++; $display("FAIL debris_255: got %0d expected 255", debris_cnt);
    end
    run_move(1'b1, 2'b10, 1'b0, a, d, b);
    n_checks++;
    if (debris_cnt !== 8'd255 || d !== 1'b1) begin
      n_fail++; $display("FAIL debris_sat: got %0d done=%b expected 255,1", debris_cnt, d);
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_acks [3];
`ifdef ROBO_SCHED_FAIR_EN
    exp_acks = '{2'b10, 2'b01, 2'b10};
`else
    exp_acks = '{2'b10, 2'b10, 2'b10};
`endif
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    man_req = 1'b1; man_cmd = 2'b11;
    auto_req = 1'b1; auto_cmd = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      n_checks++;
      if ({man_ack, auto_ack} !== exp_acks[i] || busy !== 1'b0) begin
        n_fail++; $display("FAIL arb_%0d: man/auto ack=%b busy=%b expected %b,0", i, {man_ack, auto_ack}, busy, exp_acks[i]);
      end
    end
    man_req = 1'b0;
    cyc(1);
    n_checks++;
    if ({man_ack, auto_ack} !== 2'b01) begin
      n_fail++; $display("FAIL arb_auto_only: man/auto ack=%b expected 01", {man_ack, auto_ack});
    end
    auto_req = 1'b0;
    cyc(1);
    n_checks++;
    if ({man_ack, auto_ack} !== 2'b00) begin
      n_fail++; $display("FAIL arb_idle: man/auto ack=%b expected 00", {man_ack, auto_ack});
    end
  endtask

  task automatic test_nop();
    logic saw_done = 1'b0;
    man_req = 1'b1; man_cmd = 2'b11;
    cyc(1);
    n_checks++;
    if (man_ack !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL nop_ack: ack=%b busy=%b expected 1,0", man_ack, busy);
    end
    man_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame_tick();
      saw_done = saw_done | done | busy;
    end
    n_checks++;
    if (saw_done !== 1'b0 || dir !== 2'b01 || {pos_col, pos_row} !== {5'd3, 4'd2}) begin
      n_fail++; $display("FAIL nop_effect: done|busy=%b dir=%0d pos=(%0d,%0d) expected 0,1,(3,2)", saw_done, dir, pos_col, pos_row);
    end
  endtask

  task automatic test_reset_mid_exec();
    man_req = 1'b1; man_cmd = 2'b00;
    cyc(1);
    man_req = 1'b0;
    repeat (5) frame_tick();
    n_checks++;
    if (anim_frame !== 3'd5 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_exec: anim=%0d busy=%b expected 5,1", anim_frame, busy);
    end
    man_req = 1'b1;
    rst_n = 1'b0;
    cyc(2);
    n_checks++;
    if ({man_ack, busy, done, anim_frame} !== 6'b0 || {pos_col, pos_row} !== {5'd3, 4'd2}) begin
      n_fail++; $display("FAIL abort: ack/busy/done/anim=%b pos=(%0d,%0d) expected 0,(3,2)", {man_ack, busy, done, anim_frame}, pos_col, pos_row);
    end
    rst_n = 1'b1;
    cyc(1);
    n_checks++;
    if (man_ack !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL regrant: ack=%b busy=%b expected 1,1", man_ack, busy);
    end
    man_req = 1'b0;
    repeat (FPM) frame_tick();
    n_checks++;
    if (done !== 1'b1 || {pos_col, pos_row} !== {5'd4, 4'd2}) begin
      n_fail++; $display("FAIL regrant_commit: done=%b pos=(%0d,%0d) expected 1,(4,2)", done, pos_col, pos_row);
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_turn_wrap();
    test_edge_clamp();
    test_blocked();
    test_debris();
    test_arbitration();
    test_nop();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
